siso_frame_scheduler: RTL and testbench

- Two-requester scheduler that owns a single MSB-first serial shift path and shares it between requesters.
- Round-robin arbitration between req0 and req1; each accepted WIDTH-bit parallel word is serialized as one frame.
- Each bit is held for BIT_PERIOD clocks, and a programmable idle gap follows every frame.
- Sits between parallel producers and the serial link.

---
 rtl/siso_frame_scheduler.sv | 120 ++++++++++++
 tb/tb_siso_frame_scheduler.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/siso_frame_scheduler.sv
// siso_frame_scheduler: round-robin two-requester scheduler driving one MSB-first serial link
module siso_frame_scheduler #(
    parameter int WIDTH      = 8,
    parameter int BIT_PERIOD = 1,
    parameter int GAP_CYCLES = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req1_ready,
    output logic             serial_out,
    output logic             shift_en,
    output logic             frame_active,
    output logic             grant_id,
    output logic             done,
    output logic             busy
);
    localparam int BW = $clog2(WIDTH + 1);
    localparam int PW = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD + 1) : 1;
    localparam int GW = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES - 1) : 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
    localparam logic [PW-1:0] PER_LAST = PW'(BIT_PERIOD - 1);
    // The done cycle already counts as the first gap cycle, so GAP holds for GAP_CYCLES-1 cycles.
    localparam logic [GW-1:0] GAP_LOAD = GW'((GAP_CYCLES > 1) ? GAP_CYCLES - 2 : 0);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

    state_t           state_q, state_d;
    logic             prio_q, prio_d;
    logic             grant_q, grant_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [PW-1:0]    per_q, per_d;
    logic [GW-1:0]    gap_q, gap_d;

    wire idle  = state_q == S_IDLE;
    wire shift = state_q == S_SHIFT;

    // Ready follows the arbitration result combinationally; prio only breaks ties.
    assign req0_ready   = idle & req0_valid & (~req1_valid | ~prio_q);
    assign req1_ready   = idle & req1_valid & (~req0_valid | prio_q);
    assign serial_out   = shift & sreg_q[WIDTH-1];
    assign shift_en     = shift & (per_q == '0);
    assign frame_active = shift;
    assign grant_id     = grant_q;
    assign done         = done_q;
    assign busy         = ~idle;

    // Next-state: accept in IDLE, bit/period counting in SHIFT, idle spacing in GAP.
    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        grant_d = grant_q;
        done_d  = 1'b0;
        sreg_d  = sreg_q;
        bit_d   = bit_q;
        per_d   = per_q;
        gap_d   = gap_q;
        case (state_q)
            S_IDLE: begin
                if (req0_ready | req1_ready) begin
                    sreg_d  = req1_ready ? req1_data : req0_data;
                    grant_d = req1_ready;
                    prio_d  = ~req1_ready;
                    bit_d   = '0;
                    per_d   = '0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (per_q == PER_LAST) begin
                    per_d = '0;
                    if (bit_q == BIT_LAST) begin
                        done_d  = 1'b1;
                        gap_d   = GAP_LOAD;
                        state_d = (GAP_CYCLES > 1) ? S_GAP : S_IDLE;
                    end else begin
                        sreg_d = sreg_q << 1;
                        bit_d  = bit_q + 1'b1;
                    end
                end else begin
                    per_d = per_q + 1'b1;
                end
            end
            S_GAP: begin
                if (gap_q == '0) state_d = S_IDLE;
                else gap_d = gap_q - 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register; reset aborts any frame in flight and forgets the word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            prio_q  <= 1'b0;
            grant_q <= 1'b0;
            done_q  <= 1'b0;
            sreg_q  <= '0;
            bit_q   <= '0;
            per_q   <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            sreg_q  <= sreg_d;
            bit_q   <= bit_d;
            per_q   <= per_d;
            gap_q   <= gap_d;
        end
    end
endmodule

// File: tb/tb_siso_frame_scheduler.sv
// tb_siso_frame_scheduler: directed checks on three parameterisations of the scheduler
module tb_siso_frame_scheduler;
    logic       clk;
    logic       rst_n [3];
    logic       v0 [3], v1 [3], r0 [3], r1 [3];
    logic [7:0] d0 [3], d1 [3];
    logic       so [3], se [3], fa [3], gid [3], dn [3], bs [3];
    int         checks = 0;
    int         errors = 0;

    // Instance 0: BIT_PERIOD=1 GAP=1; instance 1: BIT_PERIOD=3; instance 2: GAP=4.
    for (genvar g = 0; g < 3; g++) begin : g_dut
        siso_frame_scheduler #(
            .WIDTH(8),
            .BIT_PERIOD((g == 1) ? 3 : 1),
            .GAP_CYCLES((g == 2) ? 4 : 1)
        ) u_dut (
            .clk(clk), .reset_n(rst_n[g]),
            .req0_valid(v0[g]), .req0_data(d0[g]), .req0_ready(r0[g]),
            .req1_valid(v1[g]), .req1_data(d1[g]), .req1_ready(r1[g]),
            .serial_out(so[g]), .shift_en(se[g]), .frame_active(fa[g]),
            .grant_id(gid[g]), .done(dn[g]), .busy(bs[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Checks one whole frame starting in the first cycle after the accept edge.
    task automatic bits(input int k, input logic [7:0] b, input int bp, input logic g);
        for (int i = 0; i < 8; i++) begin
            for (int c = 0; c < bp; c++) begin
                chk("serial_out", so[k], b[7-i]);
                chk("shift_en", se[k], c == 0);
                chk("frame_active", fa[k], 1);
                chk("ready_in_shift", r0[k] | r1[k], 0);
                chk("grant_id", gid[k], g);
                chk("done_early", dn[k], 0);
                step();
            end
        end
    endtask

    task automatic pulse_reset(input int k);
        rst_n[k] = 1'b0;
        #2;
        rst_n[k] = 1'b1;
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            rst_n[k] = 1'b0;
            v0[k] = 1'b0; v1[k] = 1'b0; d0[k] = 8'h00; d1[k] = 8'h00;
        end
        #2;
        for (int k = 0; k < 3; k++) begin
            chk("rst_serial", so[k], 0);
            chk("rst_active", fa[k], 0);
            chk("rst_done", dn[k], 0);
            chk("rst_busy", bs[k], 0);
            chk("rst_shift_en", se[k], 0);
            chk("rst_grant", gid[k], 0);
        end
        step();
        step();
        for (int k = 0; k < 3; k++) rst_n[k] = 1'b1;
        step();

        // Single frame 0xA5 from req0.
        v0[0] = 1'b1; d0[0] = 8'hA5;
        #1 chk("single_ready0", r0[0], 1);
        step();
        v0[0] = 1'b0;
        bits(0, 8'hA5, 1, 0);
        chk("single_done", dn[0], 1);
        chk("single_done_active", fa[0], 0);
        chk("single_done_serial", so[0], 0);
        chk("single_grant", gid[0], 0);
        v0[0] = 1'b1;
        #1 chk("single_next_accept", r0[0], 1);
        v0[0] = 1'b0;
        pulse_reset(0);
        step();

        // Tie arbitration with both requesters held valid.
        v0[0] = 1'b1; v1[0] = 1'b1; d0[0] = 8'hF0; d1[0] = 8'h0F;
        #1 chk("tie1_ready0", r0[0], 1);
        chk("tie1_ready1", r1[0], 0);
        step();
        bits(0, 8'hF0, 1, 0);
        chk("tie1_done", dn[0], 1);
        chk("tie2_ready1", r1[0], 1);
        chk("tie2_ready0", r0[0], 0);
        step();
        bits(0, 8'h0F, 1, 1);
        chk("tie2_done", dn[0], 1);
        chk("tie3_ready0", r0[0], 1);
        chk("tie3_ready1", r1[0], 0);
        step();
        v0[0] = 1'b0; v1[0] = 1'b0;
        bits(0, 8'hF0, 1, 0);
        chk("tie3_done", dn[0], 1);
        step();

        // Slow bit period on instance 1.
        v1[1] = 1'b1; d1[1] = 8'h81;
        #1 chk("slow_ready1", r1[1], 1);
        step();
        v1[1] = 1'b0;
        bits(1, 8'h81, 3, 1);
        chk("slow_done", dn[1], 1);
        chk("slow_done_active", fa[1], 0);
        step();

        // Gap of 4 cycles on instance 2 with req0 held.
        v0[2] = 1'b1; d0[2] = 8'h55;
        #1 chk("gap_ready0", r0[2], 1);
        step();
        bits(2, 8'h55, 1, 0);
        for (int g = 0; g < 3; g++) begin
            chk("gap_done", dn[2], g == 0);
            chk("gap_ready_low", r0[2], 0);
            chk("gap_active", fa[2], 0);
            chk("gap_busy", bs[2], 1);
            step();
        end
        chk("gap_reaccept", r0[2], 1);
        chk("gap_idle_active", fa[2], 0);
        d0[2] = 8'hC3;
        step();
        v0[2] = 1'b0;
        bits(2, 8'hC3, 1, 0);
        chk("gap2_done", dn[2], 1);
        step();

        // Reset in the middle of a 0xFF frame, req1 pending.
        v0[0] = 1'b1; d0[0] = 8'hFF;
        step();
        v0[0] = 1'b0; v1[0] = 1'b1; d1[0] = 8'h3C;
        step(); step(); step();
        chk("mid_serial_before", so[0], 1);
        #2 rst_n[0] = 1'b0;
        #1;
        chk("abort_serial", so[0], 0);
        chk("abort_active", fa[0], 0);
        chk("abort_shift_en", se[0], 0);
        chk("abort_busy", bs[0], 0);
        chk("abort_done", dn[0], 0);
        v0[0] = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("abort_no_done", dn[0], 0);
        end
        rst_n[0] = 1'b1;
        #1 chk("post_rst_tie0", r0[0], 1);
        chk("post_rst_tie1", r1[0], 0);
        v0[0] = 1'b0;
        #1 chk("post_rst_ready1", r1[0], 1);
        step();
        v1[0] = 1'b0;
        bits(0, 8'h3C, 1, 1);
        chk("post_rst_done", dn[0], 1);
        step();

        // req1 valid pulses for one cycle while busy and is withdrawn.
        v0[0] = 1'b1; d0[0] = 8'h96;
        step();
        v0[0] = 1'b0;
        fork
            begin
                v1[0] = 1'b1; d1[0] = 8'h77;
                step();
                v1[0] = 1'b0;
            end
            bits(0, 8'h96, 1, 0);
        join
        chk("wd_done", dn[0], 1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("wd_no_frame", fa[0], 0);
            chk("wd_grant", gid[0], 0);
            chk("wd_idle", bs[0], 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
